// File: rtl/conv_sequencer.sv
// conv_sequencer: drives a convolver through kernel load, image streaming and pipeline drain,
// and generates the result-BRAM write stream.
module conv_sequencer #(
  parameter int BIT_LEN    = 8,
  parameter int M_LEN      = 3,
  parameter int NB_ADDRESS = 10,
  parameter int LAST_ADDR  = 440,
  parameter int CONV_LAT   = 6
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_hold,
  input  logic                  i_abort,
  output logic                  o_selecK_I,
  output logic                  o_valid,
  output logic [1:0]            o_kernel_idx,
  output logic [NB_ADDRESS-1:0] o_read_addr,
  output logic [NB_ADDRESS-1:0] o_write_addr,
  output logic                  o_wr_en,
  output logic                  o_mem_sel,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KLOAD  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam int VMAX = LAST_ADDR + CONV_LAT + 1;
  localparam int VW   = $clog2(VMAX + 1);
  localparam logic [NB_ADDRESS-1:0] A_LAST = NB_ADDRESS'(LAST_ADDR);
  localparam logic [VW-1:0]         V_MAX  = VW'(VMAX);
  localparam logic [VW-1:0]         V_LAT  = VW'(CONV_LAT);
  localparam logic [1:0]            K_LAST = 2'(M_LEN - 1);

  if (BIT_LEN < 1 || M_LEN < 1 || M_LEN > 4) begin : g_bad_param
    $error("conv_sequencer: unsupported BIT_LEN/M_LEN");
  end

  logic [2:0]            state_q, state_d;
  logic [1:0]            kidx_q, kidx_d;
  logic [NB_ADDRESS-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic                  valid_q, valid_d, sel_q, sel_d, wr_en_q, wr_en_d;
  logic                  busy_q, busy_d, done_q, done_d, mem_sel_q, mem_sel_d;
  logic                  beat, last_wr, run_d;

  // Registers hold the beat presented in the current cycle; the comb block plans the next one.
  always_comb begin
    beat    = valid_q && sel_q;
    last_wr = wr_en_q && waddr_q == A_LAST;
    state_d = state_q;
    kidx_d  = kidx_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    vcnt_d  = vcnt_q;
    if (i_abort) begin
      state_d = S_IDLE;
      kidx_d  = '0;
      raddr_d = '0;
      waddr_d = '0;
      vcnt_d  = '0;
    end else begin
      waddr_d = (wr_en_q && !last_wr) ? waddr_q + 1'b1 : waddr_q;
      vcnt_d  = (beat && vcnt_q != V_MAX) ? vcnt_q + 1'b1 : vcnt_q;
      if ((state_q == S_IDLE || state_q == S_DONE) && i_start) begin
        state_d = S_KLOAD;
        kidx_d  = '0;
        raddr_d = '0;
        waddr_d = '0;
        vcnt_d  = '0;
      end else if (state_q == S_KLOAD) begin
        state_d = kidx_q == K_LAST ? S_STREAM : S_KLOAD;
        kidx_d  = kidx_q == K_LAST ? kidx_q : kidx_q + 1'b1;
      end else if (state_q == S_STREAM || state_q == S_DRAIN) begin
        raddr_d = (beat && raddr_q != A_LAST) ? raddr_q + 1'b1 : raddr_q;
        state_d = last_wr ? S_DONE : (beat && raddr_q == A_LAST) ? S_DRAIN : state_q;
      end else if (state_q > S_DONE) begin
        state_d = S_IDLE;
      end
    end
    run_d     = state_d == S_STREAM || state_d == S_DRAIN;
    busy_d    = state_d == S_KLOAD || run_d;
    valid_d   = state_d == S_KLOAD || (run_d && !i_hold);
    sel_d     = run_d;
    wr_en_d   = run_d && valid_d && vcnt_d >= V_LAT;
    done_d    = state_d == S_DONE;
    mem_sel_d = busy_d;
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      kidx_q    <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      vcnt_q    <= '0;
      valid_q   <= 1'b0;
      sel_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kidx_q    <= kidx_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      vcnt_q    <= vcnt_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  assign o_selecK_I   = sel_q;
  assign o_valid      = valid_q;
  assign o_kernel_idx = kidx_q;
  assign o_read_addr  = raddr_q;
  assign o_write_addr = waddr_q;
  assign o_wr_en      = wr_en_q;
  assign o_mem_sel    = mem_sel_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed runs; expected kernel/read/write beats queued at start,
// popped and compared by a negedge monitor.
module tb_conv_sequencer;
  localparam int LAST = 440;
  localparam int LAT  = 6;
  localparam int M    = 3;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic       sel, valid, wr_en, mem_sel, busy, done;
  logic [1:0] kidx;
  logic [9:0] raddr, waddr;
  int tests = 0, fails = 0, busy_cnt = 0, ibeat = 0;
  int kq[$], rq[$], wq[$], wbq[$];

  conv_sequencer dut (
    .CLK100MHZ(clk), .i_reset_n(rst_n), .i_start(start), .i_hold(hold), .i_abort(abort),
    .o_selecK_I(sel), .o_valid(valid), .o_kernel_idx(kidx), .o_read_addr(raddr),
    .o_write_addr(waddr), .o_wr_en(wr_en), .o_mem_sel(mem_sel), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (busy) busy_cnt++;
    if (valid && !sel) begin
      if (kidx == 2'd0) ibeat = 0;
      if (kq.size() == 0) check("kernel_extra", kidx, -1);
      else check("kernel_idx", kidx, kq.pop_front());
    end
    if (valid && sel) begin
      ibeat++;
      if (rq.size() == 0) check("read_extra", raddr, -1);
      else check("read_addr", raddr, rq.pop_front());
    end
    if (wr_en) begin
      if (wq.size() == 0) check("write_extra", waddr, -1);
      else begin
        check("write_addr", waddr, wq.pop_front());
        check("write_beat", ibeat, wbq.pop_front());
      end
    end
  end

  task automatic push_run();
    for (int i = 0; i < M; i++) kq.push_back(i);
    for (int i = 0; i <= LAST; i++) rq.push_back(i);
    for (int i = 0; i < LAT; i++) rq.push_back(LAST);
    for (int i = 0; i <= LAST; i++) begin
      wq.push_back(i);
      wbq.push_back(i + LAT + 1);
    end
  endtask

  task automatic flush();
    kq.delete();
    rq.delete();
    wq.delete();
    wbq.delete();
  endtask

  task automatic start_run();
    push_run();
    busy_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_raddr(input int v);
    int n = 0;
    while (!(valid && sel && raddr == v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_raddr", int'(valid && sel && raddr == v), 1);
  endtask

  task automatic wait_waddr(input int v);
    int n = 0;
    while (!(wr_en && waddr == v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_waddr", int'(wr_en && waddr == v), 1);
  endtask

  task automatic wait_done(input int exp_busy);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("kernel_left", kq.size(), 0);
    check("read_left", rq.size(), 0);
    check("write_left", wq.size(), 0);
    check("done_raddr", raddr, LAST);
    check("done_waddr", waddr, LAST);
    check("done_memsel", mem_sel, 0);
    check("done_valid", valid, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_memsel", mem_sel, 0);
    check("rst_sel", sel, 0);
    check("rst_kidx", kidx, 0);
    check("rst_raddr", raddr, 0);
    check("rst_waddr", waddr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_memsel", mem_sel, 0);
    @(negedge clk);
    check("start_abort_idle", busy, 0);

    start_run();
    wait_done(450);

    start_run();
    check("restart_done_drop", done, 0);
    check("restart_busy", busy, 1);
    wait_raddr(100);
    hold = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", valid, 0);
      check("hold_raddr", raddr, 101);
    end
    hold = 1'b0;
    wait_done(455);

    push_run();
    busy_cnt = 0;
    start = 1'b1;
    hold = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hold = 1'b0;
    wait_raddr(LAST);
    @(negedge clk);
    hold = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("drain_hold_valid", valid, 0);
      check("drain_hold_raddr", raddr, LAST);
      check("drain_hold_busy", busy, 1);
    end
    hold = 1'b0;
    wait_done(454);

    start_run();
    wait_raddr(200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_memsel", mem_sel, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_valid", valid, 0);
    check("abort_raddr", raddr, 0);
    check("abort_waddr", waddr, 0);
    flush();
    @(negedge clk);

    start_run();
    wait_raddr(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(450);

    start_run();
    wait_waddr(50);
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_busy", busy, 0);
    check("arst_memsel", mem_sel, 0);
    check("arst_sel", sel, 0);
    check("arst_kidx", kidx, 0);
    check("arst_raddr", raddr, 0);
    check("arst_waddr", waddr, 0);
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_valid", valid, 0);

    start_run();
    wait_done(450);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter BIT_LEN, default 8, kernel/pixel sample width.
REQ-002 Parameter M_LEN, default 3, number of kernel columns loaded per run.
REQ-003 Parameter NB_ADDRESS, default 10, BRAM address width.
REQ-004 Parameter LAST_ADDR, default 440, last image read/write address.
REQ-005 Parameter CONV_LAT, default 6, convolver latency in valid beats.
REQ-006 CLK100MHZ  in  1  single clock; all state changes on its rising edge.
REQ-007 i_reset_n  in  1  asynchronous, active-low reset.
REQ-008 i_start  in  1  run request; sampled in IDLE or DONE only.
REQ-009 i_hold  in  1  stall; freezes streaming and counters while high.
REQ-010 i_abort  in  1  synchronous abort to IDLE; has priority over all other inputs except reset.
REQ-011 o_selecK_I  out  1  0 = kernel load, 1 = image data, to convolver.
REQ-012 o_valid  out  1  convolver valid beat.
REQ-013 o_kernel_idx  out  2  kernel column index presented during load.
REQ-014 o_read_addr  out  NB_ADDRESS  BRAM read address.
REQ-015 o_write_addr  out  NB_ADDRESS  result BRAM write address.
REQ-016 o_wr_en  out  1  result BRAM write enable.
REQ-017 o_mem_sel  out  1  1 = BRAM addresses owned by sequencer, 0 = host-owned.
REQ-018 o_busy  out  1  high in KLOAD, STREAM and DRAIN.
REQ-019 o_done  out  1  high in DONE.

Function
REQ-020 All outputs SHALL be registered and decoded from state and counters.
REQ-021 States SHALL be IDLE, KLOAD, STREAM, DRAIN, DONE.
- IDLE: on i_start, go to KLOAD.
- DONE: on i_start, go to KLOAD.
REQ-022 KLOAD SHALL last exactly M_LEN cycles.
- o_selecK_I=0, o_valid=1, o_kernel_idx = 0..M_LEN-1.
- i_hold is ignored in KLOAD.
- Then go to STREAM.
REQ-023 In STREAM, o_selecK_I=1 and o_valid = !i_hold.
- Each valid beat increments o_read_addr, starting from 0.
- The beat issuing LAST_ADDR transitions to DRAIN.
REQ-024 In DRAIN, o_read_addr SHALL hold at LAST_ADDR and o_valid = !i_hold.
- DRAIN issues exactly CONV_LAT valid beats.
REQ-025 Internal counter vcnt SHALL count valid beats in STREAM+DRAIN.
- Cleared on KLOAD entry.
- Saturates at LAST_ADDR+CONV_LAT+1.
REQ-026 o_wr_en SHALL equal o_valid && vcnt >= CONV_LAT, with vcnt taken before the current beat's increment.
REQ-027 o_write_addr SHALL start at 0 and increment after each o_wr_en beat.
- Exactly LAST_ADDR+1 writes per run, addresses 0..LAST_ADDR.
REQ-028 The final write beat (o_write_addr==LAST_ADDR) SHALL transition to DONE.
REQ-029 o_mem_sel SHALL be 1 in KLOAD/STREAM/DRAIN and 0 in IDLE/DONE.
REQ-030 In IDLE/DONE, o_valid=0, o_wr_en=0, and addresses hold their last values.
REQ-031 i_start while busy SHALL be ignored.
REQ-032 i_abort SHALL force IDLE and clear counters next cycle.
- o_wr_en=0 in that cycle.
- If i_start and i_abort are high together, i_abort wins.
REQ-033 No address SHALL wrap; counters never exceed LAST_ADDR.

Reset
REQ-034 On i_reset_n low, immediately and asynchronously:
- state=IDLE.
- o_valid, o_wr_en, o_busy, o_done, o_mem_sel, o_selecK_I, o_kernel_idx all 0.
- o_read_addr and o_write_addr = 0.
REQ-035 Reset mid-run SHALL discard the run; a new i_start is required after release.

Verification
REQ-036 Nominal run, defaults, i_start at edge 0 ->
- KLOAD for 3 cycles, kernel_idx 0,1,2.
- STREAM for 441 cycles, read_addr 0..440.
- DRAIN for 6 cycles.
- o_wr_en first high on the 7th image beat; 441 writes, addresses 0..440.
- o_done high after the final write; 450 cycles of activity total.
REQ-037 i_hold high for 5 cycles at read_addr 100 ->
- o_valid=0 and all counters frozen for 5 cycles.
- Run ends exactly 5 cycles later than nominal; write count still 441.
REQ-038 i_hold during KLOAD and DRAIN ->
- KLOAD duration unchanged.
- DRAIN extends by the hold length.
REQ-039 i_abort at read_addr 200 ->
- Next cycle IDLE, o_mem_sel=0, o_wr_en=0, counters 0.
- A subsequent i_start performs a full nominal run.
REQ-040 i_start re-asserted during STREAM -> no effect.
- i_start in DONE -> new KLOAD; o_done drops the next cycle.
REQ-041 i_reset_n pulsed low at write_addr 50 ->
- All outputs 0 asynchronously.
- Stays IDLE after release until i_start.
